// File: rtl/bram_burst_pkg.sv
// Shared types and constants for the burst controller in front of the cache RAM.
package bram_burst_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_LEN_W  = 8;

    // Read-return buffer depth: one entry covers the RAM latency, one covers a stalled consumer.
    localparam int BUF_DEPTH = 2;
    localparam int OCC_W     = $clog2(BUF_DEPTH + 1);
    localparam int PTR_W     = $clog2(BUF_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ,
        DRAIN
    } state_e;

endpackage

// File: rtl/bram_burst_ctrl_if.sv
// Command, write-beat and read-beat streams of the burst controller.
// The master side is the upstream client; the slave side is bram_burst_ctrl.
interface bram_burst_ctrl_if
    import bram_burst_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int LEN_W  = DEF_LEN_W
) ();

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;

    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] wr_data;

    logic              rd_valid;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;
    logic              rd_last;

    modport master (
        output cmd_valid, cmd_write, cmd_addr, cmd_len,
        output wr_valid, wr_data,
        output rd_ready,
        input  cmd_ready, wr_ready, rd_valid, rd_data, rd_last
    );

    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len,
        input  wr_valid, wr_data,
        input  rd_ready,
        output cmd_ready, wr_ready, rd_valid, rd_data, rd_last
    );

endinterface

// File: rtl/bram_rd_skid_fifo.sv
// Two-entry FIFO that absorbs the RAM's read latency so a stalled consumer
// never loses a beat. Exposes occupancy so the controller can meter reads.
module bram_rd_skid_fifo
    import bram_burst_pkg::*;
#(
    parameter int WIDTH = DEF_DATA_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic [OCC_W-1:0] occupancy
);

    logic [WIDTH-1:0] mem_q [BUF_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [OCC_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign empty     = (count_q == '0);
    assign do_push   = push && (count_q != OCC_W'(BUF_DEPTH));
    assign do_pop    = pop && !empty;
    assign pop_data  = mem_q[rd_ptr_q];
    assign occupancy = count_q;

    // Capture pushed words into storage.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: storage is reset only because it is two words and rd_data must read 0
        // out of reset; the large cache RAM itself is deliberately never reset.
        if (!rst_n) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // Advance pointers and track occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_q + OCC_W'(do_push) - OCC_W'(do_pop);
        end
    end

endmodule

// File: rtl/bram_burst_ctrl.sv
// Burst access controller for the 256x32 cache RAM. Takes one command at a
// time and streams write beats into the RAM or read beats out of it.
// The RAM samples on the falling edge, so a read issued in cycle N is pushed
// into the return buffer at the rising edge that closes cycle N.
// Optional build macro BRAM_BURST_BOUNDARY_CHK_EN: rejects commands that would
// run past the top address, pulsing cmd_err instead of wrapping.
module bram_burst_ctrl
    import bram_burst_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic                clk,
    input  logic                rst_n,
    bram_burst_ctrl_if.slave    bus,
    output logic                busy,
    output logic                ram_w_en,
    output logic                ram_r_en,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic [DATA_W-1:0]   ram_data_in,
    input  logic [DATA_W-1:0]   ram_data_o
`ifdef BRAM_BURST_BOUNDARY_CHK_EN
    ,
    output logic                cmd_err
`endif
);

    state_e            state_q;
    state_e            state_d;
    logic [ADDR_W-1:0] cur_q;
    logic [LEN_W-1:0]  rem_q;
    logic              cmd_fire;
    logic              beat_fire;
    logic              last_beat;
    logic              cmd_bad;
    logic              fifo_pop;
    logic              fifo_empty;
    logic [OCC_W-1:0]  fifo_occ;
    logic [DATA_W:0]   fifo_head;

    assign last_beat   = (rem_q == '0);
    assign ram_addr    = cur_q;
    assign ram_data_in = bus.wr_data;

`ifdef BRAM_BURST_BOUNDARY_CHK_EN
    localparam int SUM_W = ((ADDR_W > LEN_W) ? ADDR_W : LEN_W) + 1;
    logic [SUM_W-1:0] cmd_end;
    assign cmd_end = SUM_W'(bus.cmd_addr) + SUM_W'(bus.cmd_len);
    assign cmd_bad = (cmd_end > SUM_W'((1 << ADDR_W) - 1));
`else
    assign cmd_bad = 1'b0;
`endif

    // Next-state and RAM/handshake strobes decoded from the current state.
    always_comb begin
        // NOTE: every signal written here gets a default first so no path infers a latch.
        state_d       = state_q;
        bus.cmd_ready = 1'b0;
        bus.wr_ready  = 1'b0;
        ram_w_en      = 1'b0;
        ram_r_en      = 1'b0;
        cmd_fire      = 1'b0;
        beat_fire     = 1'b0;
        case (state_q)
            IDLE: begin
                // rst_n gate keeps cmd_ready low while reset is held.
                bus.cmd_ready = rst_n;
                if (bus.cmd_valid && rst_n) begin
                    cmd_fire = 1'b1;
                    if (!cmd_bad) begin
                        state_d = bus.cmd_write ? WRITE : READ;
                    end
                end
            end
            WRITE: begin
                bus.wr_ready = 1'b1;
                if (bus.wr_valid) begin
                    ram_w_en  = 1'b1;
                    beat_fire = 1'b1;
                    if (last_beat) begin
                        state_d = IDLE;
                    end
                end
            end
            READ: begin
                // Any read issued earlier has already landed in the buffer, so
                // buffer occupancy alone is the credit count.
                if (fifo_occ < OCC_W'(BUF_DEPTH)) begin
                    ram_r_en  = 1'b1;
                    beat_fire = 1'b1;
                    if (last_beat) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (fifo_empty) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, current address and remaining-beat registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state_q <= IDLE;
            cur_q   <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            if (cmd_fire) begin
                cur_q <= bus.cmd_addr;
                rem_q <= bus.cmd_len;
            end else if (beat_fire) begin
                cur_q <= cur_q + ADDR_W'(1);
                rem_q <= rem_q - LEN_W'(1);
            end
        end
    end

`ifdef BRAM_BURST_BOUNDARY_CHK_EN
    // One-cycle error pulse for an accepted but out-of-range command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_err <= 1'b0;
        end else begin
            cmd_err <= cmd_fire && cmd_bad;
        end
    end
`endif

    assign fifo_pop     = bus.rd_valid && bus.rd_ready;
    assign bus.rd_valid = !fifo_empty;
    assign bus.rd_data  = fifo_head[DATA_W-1:0];
    assign bus.rd_last  = fifo_head[DATA_W];
    assign busy         = (state_q != IDLE) || !fifo_empty;

    bram_rd_skid_fifo #(
        .WIDTH (DATA_W + 1)
    ) u_rd_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (ram_r_en),
        .push_data ({last_beat, ram_data_o}),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .empty     (fifo_empty),
        .occupancy (fifo_occ)
    );

endmodule

// File: tb/tb_bram_burst_ctrl.sv
// Directed bench for bram_burst_ctrl with a behavioural negedge-sampled RAM.
module tb_bram_burst_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        busy;
    logic        ram_w_en;
    logic        ram_r_en;
    logic [7:0]  ram_addr;
    logic [31:0] ram_data_in;
    logic [31:0] ram_data_o = '0;
`ifdef BRAM_BURST_BOUNDARY_CHK_EN
    logic        cmd_err;
`endif

    bram_burst_ctrl_if bus ();

    bram_burst_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .busy        (busy),
        .ram_w_en    (ram_w_en),
        .ram_r_en    (ram_r_en),
        .ram_addr    (ram_addr),
        .ram_data_in (ram_data_in),
        .ram_data_o  (ram_data_o)
`ifdef BRAM_BURST_BOUNDARY_CHK_EN
        ,
        .cmd_err     (cmd_err)
`endif
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] ram     [256];
    logic [31:0] exp_mem [256];
    logic [32:0] rlog [$];
    int w_count     = 0;
    int r_count     = 0;
    int issued      = 0;
    int popped      = 0;
    int credit_viol = 0;

    // RAM model plus stream monitor, all sampled mid-cycle.
    always @(negedge clk) begin
        if (ram_w_en) begin
            ram[ram_addr] <= ram_data_in;
            w_count++;
        end
        if (ram_r_en) begin
            if (issued - popped >= 2) credit_viol++;
            ram_data_o <= ram[ram_addr];
            issued++;
            r_count++;
        end
        if (bus.rd_valid && bus.rd_ready) begin
            rlog.push_back({bus.rd_last, bus.rd_data});
            popped++;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present a command and hold it until the handshake edge; returns 1 cycle after accept.
    task automatic send_cmd(input logic wr, input logic [7:0] a, input logic [7:0] l);
        int n;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = a;
        bus.cmd_len   = l;
        n = 0;
        #1;
        while (!bus.cmd_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("cmd_ready_timeout", 64'(n < 200), 64'd1);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        #1;
    endtask

    task automatic write_burst(input string tag, input logic [7:0] a, input logic [7:0] l,
                               input logic [31:0] base, input int gap_at);
        int wc0;
        logic [7:0] ea;
        wc0 = w_count;
        send_cmd(1'b1, a, l);
        for (int i = 0; i <= int'(l); i++) begin
            if (i == gap_at) begin
                bus.wr_valid = 1'b0;
                #1;
                check({tag, "_gap_wen"}, ram_w_en, 1'b0);
                @(posedge clk); #1;
            end
            ea = 8'(int'(a) + i);
            bus.wr_valid = 1'b1;
            bus.wr_data  = base + 32'(i);
            #1;
            check({tag, "_wr_ready"}, bus.wr_ready, 1'b1);
            check({tag, "_wen"}, ram_w_en, 1'b1);
            check({tag, "_waddr"}, ram_addr, ea);
            check({tag, "_wdata"}, ram_data_in, base + 32'(i));
            exp_mem[ea] = base + 32'(i);
            @(posedge clk); #1;
        end
        bus.wr_valid = 1'b0;
        #1;
        check({tag, "_wen_after"}, ram_w_en, 1'b0);
        check({tag, "_idle_after"}, bus.cmd_ready, 1'b1);
        check({tag, "_wcount"}, 64'(w_count - wc0), 64'(int'(l) + 1));
    endtask

    task automatic read_burst(input string tag, input logic [7:0] a, input logic [7:0] l,
                              input logic [3:0] pat);
        int n;
        int beats;
        rlog.delete();
        beats = int'(l) + 1;
        bus.rd_ready = pat[0];
        send_cmd(1'b0, a, l);
        check({tag, "_valid_cyc1"}, bus.rd_valid, 1'b0);
        check({tag, "_ren_cyc1"}, ram_r_en, 1'b1);
        check({tag, "_raddr_cyc1"}, ram_addr, a);
        n = 0;
        while (rlog.size() < beats && n < 2000) begin
            bus.rd_ready = pat[n % 4];
            @(posedge clk); #1;
            if (n == 0) check({tag, "_valid_cyc2"}, bus.rd_valid, 1'b1);
            n++;
        end
        bus.rd_ready = 1'b1;
        n = 0;
        while (busy && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_busy_end"}, busy, 1'b0);
        check({tag, "_valid_end"}, bus.rd_valid, 1'b0);
        check({tag, "_beats"}, 64'(rlog.size()), 64'(beats));
        for (int i = 0; i < beats; i++) begin
            if (i < rlog.size())
                check({tag, "_beat"}, rlog[i], {(i == beats - 1), exp_mem[8'(int'(a) + i)]});
        end
    endtask

    initial begin
        int n;
        rst_n         = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_len   = '0;
        bus.wr_valid  = 1'b0;
        bus.wr_data   = '0;
        bus.rd_ready  = 1'b0;

        // Reset values.
        repeat (2) @(posedge clk);
        #1;
        check("rst_cmd_ready", bus.cmd_ready, 1'b0);
        check("rst_wr_ready", bus.wr_ready, 1'b0);
        check("rst_rd_valid", bus.rd_valid, 1'b0);
        check("rst_rd_last", bus.rd_last, 1'b0);
        check("rst_rd_data", bus.rd_data, 32'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_wen", ram_w_en, 1'b0);
        check("rst_ren", ram_r_en, 1'b0);
        check("rst_addr", ram_addr, 8'h00);
        rst_n = 1'b1;
        #1;
        check("post_rst_cmd_ready", bus.cmd_ready, 1'b1);
        @(posedge clk); #1;

        // 1: write 0x10..0x13 then read it back at full rate.
        write_burst("t1w", 8'h10, 8'd3, 32'h0000_00A0, -1);
        read_burst("t1r", 8'h10, 8'd3, 4'b1111);

        // 2: 8 beats at 0x20 with a write gap, read back under 1,0,0,1 backpressure.
        write_burst("t2w", 8'h20, 8'd7, 32'h2000_0000, 3);
        read_burst("t2r", 8'h20, 8'd7, 4'b1001);

        // 3: burst crossing the top address.
`ifdef BRAM_BURST_BOUNDARY_CHK_EN
        begin
            int wc0;
            int rc0;
            wc0 = w_count;
            rc0 = r_count;
            send_cmd(1'b1, 8'hFE, 8'd3);
            check("t3_cmd_err", cmd_err, 1'b1);
            check("t3_idle", bus.cmd_ready, 1'b1);
            check("t3_busy", busy, 1'b0);
            @(posedge clk); #1;
            check("t3_cmd_err_pulse", cmd_err, 1'b0);
            check("t3_no_writes", 64'(w_count - wc0), 64'd0);
            check("t3_no_reads", 64'(r_count - rc0), 64'd0);
        end
`else
        write_burst("t3w", 8'hFE, 8'd3, 32'h3000_0000, -1);
        read_burst("t3r", 8'hFE, 8'd3, 4'b1111);
`endif

        // 4: single-beat write and read at 0x7F.
        write_burst("t4w", 8'h7F, 8'd0, 32'h7F7F_0001, -1);
        read_burst("t4r", 8'h7F, 8'd0, 4'b1111);

        // 5: reset after 2 of 6 write beats.
        begin
            int wc0;
            wc0 = w_count;
            send_cmd(1'b1, 8'h40, 8'd5);
            for (int i = 0; i < 2; i++) begin
                bus.wr_valid = 1'b1;
                bus.wr_data  = 32'h5500_0000 + 32'(i);
                exp_mem[8'(8'h40 + i)] = 32'h5500_0000 + 32'(i);
                @(posedge clk); #1;
            end
            bus.wr_data = 32'h5500_0002;
            #1;
            check("t5_wen_before_rst", ram_w_en, 1'b1);
            rst_n = 1'b0;
            #1;
            check("t5_wen_in_rst", ram_w_en, 1'b0);
            check("t5_wr_ready_in_rst", bus.wr_ready, 1'b0);
            check("t5_cmd_ready_in_rst", bus.cmd_ready, 1'b0);
            check("t5_busy_in_rst", busy, 1'b0);
            bus.wr_valid = 1'b0;
            @(posedge clk); #1;
            rst_n = 1'b1;
            #1;
            check("t5_cmd_ready_after", bus.cmd_ready, 1'b1);
            check("t5_writes_done", 64'(w_count - wc0), 64'd2);
        end
        read_burst("t5r", 8'h40, 8'd1, 4'b1111);

        // 6: second command held during an active read burst.
        write_burst("t6w", 8'h80, 8'd3, 32'h6000_0000, -1);
        rlog.delete();
        bus.rd_ready = 1'b0;
        send_cmd(1'b0, 8'h80, 8'd3);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 8'h10;
        bus.cmd_len   = 8'd0;
        #1;
        check("t6_blocked_start", bus.cmd_ready, 1'b0);
        check("t6_busy_start", busy, 1'b1);
        repeat (4) begin
            @(posedge clk); #1;
            check("t6_blocked_stall", bus.cmd_ready, 1'b0);
        end
        bus.rd_ready = 1'b1;
        n = 0;
        while (busy && n < 50) begin
            check("t6_blocked_drain", bus.cmd_ready, 1'b0);
            @(posedge clk); #1;
            n++;
        end
        check("t6_busy_clear", busy, 1'b0);
        check("t6_accept_ready", bus.cmd_ready, 1'b1);
        check("t6_first_beats", 64'(rlog.size()), 64'd4);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        #1;
        check("t6_second_busy", busy, 1'b1);
        n = 0;
        while (busy && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("t6_second_done", busy, 1'b0);
        check("t6_total_beats", 64'(rlog.size()), 64'd5);
        for (int i = 0; i < 4; i++) begin
            if (i < rlog.size())
                check("t6_beat", rlog[i], {(i == 3), exp_mem[8'(8'h80 + i)]});
        end
        if (rlog.size() == 5)
            check("t6_second_beat", rlog[4], {1'b1, 32'h0000_00A0});

        check("credit_violations", 64'(credit_viol), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
